// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream blocks: arbitration FSM states and the
// helper that sizes source-index fields.
package stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a field able to hold any source index 0..n_src-1.
    function automatic int id_width(input int n_src);
        return (n_src > 1) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of the per-source input streams and the single arbitrated output
// stream. The master modport is the arbiter's view, the slave modport is the
// view of the surrounding logic that feeds the sources and sinks the output.
interface stream_arbiter_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int N_SRC        = 4
) ();
    import stream_pkg::*;

    localparam int ID_W = id_width(N_SRC);

    logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC];
    logic [N_SRC-1:0]        s_last_i;
    logic [N_SRC-1:0]        s_valid_i;
    logic [N_SRC-1:0]        s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic [ID_W-1:0]         m_id_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport master (
        input  s_data_i,
        input  s_last_i,
        input  s_valid_i,
        output s_ready_o,
        output m_data_o,
        output m_last_o,
        output m_id_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport slave (
        output s_data_i,
        output s_last_i,
        output s_valid_i,
        input  s_ready_o,
        input  m_data_o,
        input  m_last_o,
        input  m_id_o,
        input  m_valid_o,
        output m_ready_i
    );

endinterface

// File: rtl/stream_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping around to the lowest requester below ptr.
module rr_picker #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  gnt_o,
    output logic             any_o
);

    logic found;

    // First pass covers ptr..N_SRC-1; second pass finds the lowest requester,
    // which is the wrapped winner whenever the first pass found nothing.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && req_i[i] && (ID_W'(i) >= ptr_i)) begin
                found = 1'b1;
                gnt_o = ID_W'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                gnt_o = ID_W'(i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-level round-robin arbiter: locks onto one source for a whole packet
// and forwards its beats through a single registered output stage.
module stream_arbiter
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int N_SRC        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_arbiter_if.master bus
);

    localparam int ID_W = id_width(N_SRC);

    arb_state_t              state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic [ID_W-1:0]         m_id_q, m_id_d;
    logic                    m_valid_q, m_valid_d;

    logic [ID_W-1:0]         pick_gnt;
    logic                    pick_any;
    logic                    out_free;
    logic                    accept;
    logic [N_SRC-1:0]        s_ready;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic                    sel_last;

    rr_picker #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_picker (
        .req_i (bus.s_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    // Ready only towards the granted source, only when the output stage can
    // take a beat, and never while reset is held.
    always_comb begin
        out_free = ~m_valid_q | bus.m_ready_i;
        s_ready  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            s_ready[i] = (state_q == GRANT) && (grant_q == ID_W'(i)) && out_free && !rst_n;
            if (grant_q == ID_W'(i)) begin
                sel_data = bus.s_data_i[i];
                sel_last = bus.s_last_i[i];
            end
        end
        accept = |(s_ready & bus.s_valid_i);
    end

    // Next-state: arbitrate in IDLE, hold the grant until the last beat, and
    // load or drain the output register.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_id_d    = m_id_q;
        m_valid_d = m_valid_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept && sel_last) begin
                    ptr_d   = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            m_data_d  = sel_data;
            m_last_d  = sel_last;
            m_id_d    = grant_q;
            m_valid_d = 1'b1;
        end else if (bus.m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any partial packet and the
    // buffered beat and restarts arbitration from source 0.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_id_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_id_q    <= m_id_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_id_o    = m_id_q;
    assign bus.m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed scenarios plus a
// randomised run checked by a per-source scoreboard.
module tb_stream_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    // Free-running clock.
    always #5 clk = ~clk;

    stream_arbiter_if #(.T_DATA_WIDTH(DW), .N_SRC(NS)) bus ();

    stream_arbiter #(.T_DATA_WIDTH(DW), .N_SRC(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t srcQ [NS][$];
    bit    srcEn [NS];
    int    validPct = 100;
    int    readyPct = 100;
    obs_t  outLog [$];

    int             accId;
    int             accCount;
    beat_t          accBeat;
    logic [NS-1:0]  readySeen;
    logic           prevValid, prevReady, prevLast;
    logic [DW-1:0]  prevData;
    logic [IW-1:0]  prevId;

    // One clock cycle: drive sources from their queues, observe handshakes
    // at the falling edge, then advance past the rising edge.
    task automatic step();
        for (int i = 0; i < NS; i++) begin
            if (srcEn[i] && srcQ[i].size() > 0 && ($urandom_range(99) < validPct)) begin
                bus.s_valid_i[i] = 1'b1;
                bus.s_data_i[i]  = srcQ[i][0].data;
                bus.s_last_i[i]  = srcQ[i][0].last;
            end else begin
                bus.s_valid_i[i] = 1'b0;
                bus.s_data_i[i]  = '0;
                bus.s_last_i[i]  = 1'b0;
            end
        end
        bus.m_ready_i = ($urandom_range(99) < readyPct);
        @(negedge clk);
        readySeen = bus.s_ready_o;
        prevValid = bus.m_valid_o;
        prevReady = bus.m_ready_i;
        prevData  = bus.m_data_o;
        prevId    = bus.m_id_o;
        prevLast  = bus.m_last_o;
        accId     = -1;
        accCount  = 0;
        for (int i = 0; i < NS; i++) begin
            if (bus.s_valid_i[i] && bus.s_ready_o[i]) begin
                accId   = i;
                accBeat = srcQ[i].pop_front();
                accCount++;
            end
        end
        if (bus.m_valid_o && bus.m_ready_i)
            outLog.push_back('{int'(bus.m_id_o), bus.m_data_o, bus.m_last_o, cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        for (int i = 0; i < NS; i++) begin
            srcQ[i].delete();
            srcEn[i] = 1'b0;
        end
        validPct = 100;
        readyPct = 100;
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        outLog.delete();
    endtask

    task automatic test_reset();
        beat_t b;
        doReset();
        b.last = 1'b0; b.data = 8'hC5; srcQ[2].push_back(b);
        b.last = 1'b1; b.data = 8'h3A; srcQ[2].push_back(b);
        srcEn[2] = 1'b1;
        readyPct = 0;
        repeat (4) step();

        rst_n = 1'b1;
        readyPct = 100;
        step();
        total++;
        if (readySeen !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rst_ready_during got=%b want=0000", readySeen);
        end
        total++;
        if (bus.m_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_m_valid got=%b want=0", bus.m_valid_o);
        end
        total++;
        if (bus.m_data_o !== 8'h00) begin
            bad++;
            $display("[TB] FAIL rst_m_data got=%h want=00", bus.m_data_o);
        end
        total++;
        if (bus.m_id_o !== 2'd0) begin
            bad++;
            $display("[TB] FAIL rst_m_id got=%0d want=0", bus.m_id_o);
        end
        total++;
        if (bus.m_last_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_m_last got=%b want=0", bus.m_last_o);
        end

        rst_n = 1'b0;
        step();
        total++;
        if (readySeen !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rst_ready_after got=%b want=0000", readySeen);
        end
        total++;
        if (bus.m_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_valid_after got=%b want=0", bus.m_valid_o);
        end
    endtask

    task automatic test_round_robin();
        beat_t b;
        int    expId;
        doReset();
        for (int i = 0; i < NS; i++) begin
            for (int r = 0; r < 6; r++) begin
                b.last = 1'b1;
                b.data = DW'(8'h10 + i);
                srcQ[i].push_back(b);
            end
            srcEn[i] = 1'b1;
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if (bus.m_valid_o !== ((k % 2) == 0)) begin
                bad++;
                $display("[TB] FAIL rr_valid step=%0d got=%b want=%b", k, bus.m_valid_o, ((k % 2) == 0));
            end
            if ((k % 2) == 0) begin
                expId = ((k / 2) - 1) % NS;
                total++;
                if (bus.m_id_o !== IW'(expId)) begin
                    bad++;
                    $display("[TB] FAIL rr_id step=%0d got=%0d want=%0d", k, bus.m_id_o, expId);
                end
                total++;
                if (bus.m_data_o !== DW'(8'h10 + expId)) begin
                    bad++;
                    $display("[TB] FAIL rr_data step=%0d got=%h want=%h", k, bus.m_data_o, DW'(8'h10 + expId));
                end
            end
        end
    endtask

    task automatic test_packet_hold();
        beat_t b;
        doReset();
        for (int j = 0; j < 4; j++) begin
            b.last = (j == 3);
            b.data = DW'(8'hA0 + j);
            srcQ[2].push_back(b);
        end
        b.last = 1'b1; b.data = 8'h55; srcQ[1].push_back(b);
        b.last = 1'b1; b.data = 8'h56; srcQ[1].push_back(b);
        srcEn[2] = 1'b1;
        step();
        srcEn[1] = 1'b1;
        for (int n = 0; n < 30 && outLog.size() < 5; n++) step();
        total++;
        if (outLog.size() < 5) begin
            bad++;
            $display("[TB] FAIL hold_timeout got=%0d beats want=5", outLog.size());
            return;
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (outLog[j].id != 2 || outLog[j].data !== DW'(8'hA0 + j) || outLog[j].last !== (j == 3)) begin
                bad++;
                $display("[TB] FAIL hold_beat j=%0d got=id%0d/%h/%b want=id2/%h/%b",
                         j, outLog[j].id, outLog[j].data, outLog[j].last, DW'(8'hA0 + j), (j == 3));
            end
            if (j > 0) begin
                total++;
                if (outLog[j].cyc != outLog[0].cyc + j) begin
                    bad++;
                    $display("[TB] FAIL hold_rate j=%0d got=cyc%0d want=cyc%0d", j, outLog[j].cyc, outLog[0].cyc + j);
                end
            end
        end
        total++;
        if (outLog[4].id != 1 || outLog[4].data !== 8'h55) begin
            bad++;
            $display("[TB] FAIL hold_next got=id%0d/%h want=id1/55", outLog[4].id, outLog[4].data);
        end
    endtask

    task automatic test_valid_drop();
        beat_t b;
        doReset();
        for (int j = 0; j < 4; j++) begin
            b.last = (j == 3);
            b.data = DW'(8'hB0 + j);
            srcQ[0].push_back(b);
        end
        b.last = 1'b1; b.data = 8'h61; srcQ[1].push_back(b);
        b.last = 1'b1; b.data = 8'h63; srcQ[3].push_back(b);
        srcEn[0] = 1'b1;
        step();
        srcEn[1] = 1'b1;
        srcEn[3] = 1'b1;
        step();
        step();
        srcEn[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ((readySeen & 4'b1110) !== 4'b0000 || accCount != 0) begin
                bad++;
                $display("[TB] FAIL drop_others k=%0d got=ready%b acc%0d want=ready0xxx acc0", k, readySeen, accCount);
            end
        end
        srcEn[0] = 1'b1;
        for (int n = 0; n < 30 && outLog.size() < 5; n++) step();
        total++;
        if (outLog.size() < 5) begin
            bad++;
            $display("[TB] FAIL drop_timeout got=%0d beats want=5", outLog.size());
            return;
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (outLog[j].id != 0 || outLog[j].data !== DW'(8'hB0 + j) || outLog[j].last !== (j == 3)) begin
                bad++;
                $display("[TB] FAIL drop_beat j=%0d got=id%0d/%h/%b want=id0/%h/%b",
                         j, outLog[j].id, outLog[j].data, outLog[j].last, DW'(8'hB0 + j), (j == 3));
            end
        end
        total++;
        if (outLog[4].id != 1) begin
            bad++;
            $display("[TB] FAIL drop_next got=id%0d want=id1", outLog[4].id);
        end
    endtask

    task automatic test_backpressure();
        beat_t b;
        doReset();
        for (int j = 0; j < 4; j++) begin
            b.last = (j == 3);
            b.data = DW'(8'hC0 + j);
            srcQ[3].push_back(b);
        end
        srcEn[3] = 1'b1;
        step();
        step();
        readyPct = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if ({bus.m_valid_o, bus.m_data_o, bus.m_id_o, bus.m_last_o} !== {1'b1, 8'hC0, 2'd3, 1'b0}) begin
                bad++;
                $display("[TB] FAIL bp_hold k=%0d got=v%b/%h/id%0d/l%b want=v1/c0/id3/l0",
                         k, bus.m_valid_o, bus.m_data_o, bus.m_id_o, bus.m_last_o);
            end
            total++;
            if (readySeen !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL bp_ready k=%0d got=%b want=0000", k, readySeen);
            end
        end
        readyPct = 100;
        for (int n = 0; n < 30 && outLog.size() < 4; n++) step();
        repeat (3) step();
        total++;
        if (outLog.size() != 4) begin
            bad++;
            $display("[TB] FAIL bp_count got=%0d beats want=4", outLog.size());
            return;
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (outLog[j].id != 3 || outLog[j].data !== DW'(8'hC0 + j) || outLog[j].last !== (j == 3)) begin
                bad++;
                $display("[TB] FAIL bp_beat j=%0d got=id%0d/%h/%b want=id3/%h/%b",
                         j, outLog[j].id, outLog[j].data, outLog[j].last, DW'(8'hC0 + j), (j == 3));
            end
        end
    endtask

    task automatic test_mid_reset();
        beat_t b;
        doReset();
        b.last = 1'b1; b.data = 8'hE0; srcQ[1].push_back(b);
        for (int j = 0; j < 4; j++) begin
            b.last = (j == 3);
            b.data = DW'(8'hD0 + j);
            srcQ[2].push_back(b);
        end
        srcEn[1] = 1'b1;
        srcEn[2] = 1'b1;
        accId = -1;
        for (int n = 0; n < 20 && accId != 2; n++) step();
        total++;
        if (accId != 2) begin
            bad++;
            $display("[TB] FAIL mrst_timeout got=acc%0d want=acc2", accId);
            return;
        end
        readyPct = 0;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        total++;
        if (readySeen !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL mrst_ready got=%b want=0000", readySeen);
        end
        total++;
        if ({bus.m_valid_o, bus.m_data_o, bus.m_id_o, bus.m_last_o} !== {1'b0, 8'h00, 2'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mrst_outputs got=v%b/%h/id%0d/l%b want=v0/00/id0/l0",
                     bus.m_valid_o, bus.m_data_o, bus.m_id_o, bus.m_last_o);
        end
        for (int i = 0; i < NS; i++) begin
            srcQ[i].delete();
            srcEn[i] = 1'b1;
        end
        b.last = 1'b1; b.data = 8'hF0; srcQ[0].push_back(b);
        b.last = 1'b1; b.data = 8'hF3; srcQ[3].push_back(b);
        readyPct = 100;
        outLog.delete();
        step();
        total++;
        if (readySeen !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL mrst_ready_after got=%b want=0000", readySeen);
        end
        for (int n = 0; n < 20 && outLog.size() < 1; n++) step();
        total++;
        if (outLog.size() < 1) begin
            bad++;
            $display("[TB] FAIL mrst_regrant_timeout got=0 beats want=1");
            return;
        end
        total++;
        if (outLog[0].id != 0 || outLog[0].data !== 8'hF0) begin
            bad++;
            $display("[TB] FAIL mrst_regrant got=id%0d/%h want=id0/f0", outLog[0].id, outLog[0].data);
        end
    endtask

    task automatic test_random();
        beat_t b;
        beat_t expB;
        beat_t expQ [NS][$];
        obs_t  obs;
        int    len;
        int    seen;
        int    pktSrc;
        bit    inPkt;
        bit    done;
        doReset();
        for (int i = 0; i < NS; i++) begin
            for (int p = 0; p < 60; p++) begin
                len = $urandom_range(5, 1);
                for (int j = 0; j < len; j++) begin
                    b.data = DW'($urandom);
                    b.last = (j == len - 1);
                    srcQ[i].push_back(b);
                    expQ[i].push_back(b);
                end
            end
            srcEn[i] = 1'b1;
        end
        validPct = 70;
        readyPct = 60;
        seen   = 0;
        inPkt  = 1'b0;
        pktSrc = 0;
        done   = 1'b0;
        for (int n = 0; n < 10000 && !done; n++) begin
            step();
            total++;
            if (accCount > 1) begin
                bad++;
                $display("[TB] FAIL rand_multi_accept cyc=%0d got=%0d want<=1", cyc, accCount);
            end
            if (accCount == 1) begin
                total++;
                if ({bus.m_valid_o, bus.m_id_o, bus.m_data_o, bus.m_last_o} !==
                    {1'b1, IW'(accId), accBeat.data, accBeat.last}) begin
                    bad++;
                    $display("[TB] FAIL rand_latency cyc=%0d got=v%b/id%0d/%h/l%b want=v1/id%0d/%h/l%b",
                             cyc, bus.m_valid_o, bus.m_id_o, bus.m_data_o, bus.m_last_o,
                             accId, accBeat.data, accBeat.last);
                end
            end else if (prevValid && !prevReady) begin
                total++;
                if ({bus.m_valid_o, bus.m_id_o, bus.m_data_o, bus.m_last_o} !==
                    {1'b1, prevId, prevData, prevLast}) begin
                    bad++;
                    $display("[TB] FAIL rand_stall cyc=%0d got=v%b/id%0d/%h/l%b want=v1/id%0d/%h/l%b",
                             cyc, bus.m_valid_o, bus.m_id_o, bus.m_data_o, bus.m_last_o,
                             prevId, prevData, prevLast);
                end
            end
            while (seen < outLog.size()) begin
                obs = outLog[seen];
                seen++;
                total++;
                if (obs.id < 0 || obs.id >= NS || expQ[obs.id].size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rand_extra got=id%0d/%h want=no beat", obs.id, obs.data);
                end else begin
                    expB = expQ[obs.id].pop_front();
                    if (obs.data !== expB.data || obs.last !== expB.last) begin
                        bad++;
                        $display("[TB] FAIL rand_beat src=%0d got=%h/l%b want=%h/l%b",
                                 obs.id, obs.data, obs.last, expB.data, expB.last);
                    end
                end
                total++;
                if (inPkt && obs.id != pktSrc) begin
                    bad++;
                    $display("[TB] FAIL rand_interleave got=id%0d want=id%0d", obs.id, pktSrc);
                end
                inPkt  = !obs.last;
                pktSrc = obs.id;
            end
            done = !bus.m_valid_o;
            for (int i = 0; i < NS; i++) begin
                if (srcQ[i].size() > 0) done = 1'b0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            total++;
            if (expQ[i].size() != 0) begin
                bad++;
                $display("[TB] FAIL rand_drain src=%0d got=%0d undelivered want=0", i, expQ[i].size());
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_round_robin();
        test_packet_hold();
        test_valid_drop();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a run that never reaches the summary.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
